// File: rtl/addroundkey_stream_pkg.sv
// rtl/addroundkey_stream_pkg.sv - shared widths and lane-slice helper for the AddRoundKey stream
package addroundkey_stream_pkg;

  localparam int ARK_W_DATA = 128;
  localparam int ARK_N_KEYS = 15;

  // Beat 0 carries the MSB slice so AES byte 0 leaves first.
  function automatic int lane_msb(input int beat, input int w_data, input int w_lane);
    return w_data - 1 - beat * w_lane;
  endfunction

  function automatic int beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/addroundkey_stream_roundkey_store.sv
// rtl/addroundkey_stream_roundkey_store.sv - round-key slots with per-slot valid and lane read port
module roundkey_store
  import addroundkey_stream_pkg::*;
#(
  parameter int W_DATA = ARK_W_DATA,
  parameter int W_LANE = 32,
  parameter int N_KEYS = ARK_N_KEYS,
  parameter int W_IDX  = $clog2(N_KEYS),
  parameter int W_BEAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [W_IDX-1:0]  wr_idx,
  input  logic [W_DATA-1:0] wr_data,
  input  logic [W_IDX-1:0]  rd_idx,
  input  logic [W_BEAT-1:0] rd_beat,
  output logic [W_LANE-1:0] rd_data,
  output logic              rd_hit
);

  localparam logic [W_IDX:0] N_KEYS_W = (W_IDX + 1)'(N_KEYS);

  logic [W_DATA-1:0] key_q [N_KEYS];
  logic [W_DATA-1:0] key_d [N_KEYS];
  logic [N_KEYS-1:0] kvalid_q, kvalid_d;
  logic [W_DATA-1:0] sel_key;
  logic              wr_in_range, rd_in_range;

  assign wr_in_range = ({1'b0, wr_idx} < N_KEYS_W);
  assign rd_in_range = ({1'b0, rd_idx} < N_KEYS_W);

  always_comb begin
    key_d    = key_q;
    kvalid_d = kvalid_q;
    if (wr_en && wr_in_range) begin
      key_d[wr_idx]    = wr_data;
      kvalid_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '{default: '0};
      kvalid_q <= '0;
    end else begin
      key_q    <= key_d;
      kvalid_q <= kvalid_d;
    end
  end

  // Missing or out-of-range slots read as an all-zero key so data passes through.
  always_comb begin
    sel_key = '0;
    rd_hit  = 1'b0;
    if (rd_in_range) begin
      rd_hit = kvalid_q[rd_idx];
      if (rd_hit) sel_key = key_q[rd_idx];
    end
    rd_data = sel_key[lane_msb(int'(rd_beat), W_DATA, W_LANE) -: W_LANE];
  end

endmodule

// File: rtl/addroundkey_stream.sv
// rtl/addroundkey_stream.sv - streaming AddRoundKey: beat counter, round latch, XOR and output register
module addroundkey_stream
  import addroundkey_stream_pkg::*;
#(
  parameter int W_DATA = ARK_W_DATA,
  parameter int W_LANE = 32,
  parameter int N_KEYS = ARK_N_KEYS,
  localparam int BEATS  = W_DATA / W_LANE,
  localparam int W_IDX  = $clog2(N_KEYS),
  localparam int W_BEAT = beat_width(BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_wr_en,
  input  logic [W_IDX-1:0]  key_wr_idx,
  input  logic [W_DATA-1:0] key_wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_IDX-1:0]  in_round,
  input  logic [W_LANE-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_LANE-1:0] out_data,
  output logic              out_last,
  output logic              err_key,
  input  logic              err_clr
);

  localparam logic [W_BEAT-1:0] LAST_BEAT = W_BEAT'(BEATS - 1);

  logic [W_BEAT-1:0] beat_q, beat_d;
  logic [W_IDX-1:0]  cur_round_q, cur_round_d;
  logic              out_valid_q, out_valid_d;
  logic [W_LANE-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              err_key_q, err_key_d;

  logic              xfer, first_beat;
  logic [W_IDX-1:0]  rd_idx;
  logic [W_LANE-1:0] key_lane;
  logic              key_hit;

  assign in_ready   = !out_valid_q || out_ready;
  assign xfer       = in_valid && in_ready;
  assign first_beat = (beat_q == '0);
  assign rd_idx     = first_beat ? in_round : cur_round_q;

  roundkey_store #(
    .W_DATA (W_DATA),
    .W_LANE (W_LANE),
    .N_KEYS (N_KEYS),
    .W_IDX  (W_IDX),
    .W_BEAT (W_BEAT)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (key_wr_en),
    .wr_idx  (key_wr_idx),
    .wr_data (key_wr_data),
    .rd_idx  (rd_idx),
    .rd_beat (beat_q),
    .rd_data (key_lane),
    .rd_hit  (key_hit)
  );

  always_comb begin
    beat_d      = beat_q;
    cur_round_d = cur_round_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_key_d   = err_key_q;
    if (xfer) begin
      beat_d      = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ key_lane;
      out_last_d  = (beat_q == LAST_BEAT);
      if (first_beat) cur_round_d = in_round;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // A fresh error outranks a simultaneous clear.
    if (xfer && first_beat && !key_hit) err_key_d = 1'b1;
    else if (err_clr)                   err_key_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q      <= '0;
      cur_round_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_key_q   <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      cur_round_q <= cur_round_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_key_q   <= err_key_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err_key   = err_key_q;

endmodule

// File: tb/tb_addroundkey_stream.sv
// tb/tb_addroundkey_stream.sv - directed bench for addroundkey_stream at 32, 128 and 8-bit lanes
module tb_addroundkey_stream;

  localparam logic [127:0] K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = {128{1'b1}};
  localparam logic [127:0] S  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] E0 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] E1 = 128'h3242f4ab8c5f368a393892a9ec3a093b;
  localparam logic [127:0] E2 = 128'hcdbc095777a5cf72cece675d1fc8f8cb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_wr_en = 1'b0;
  logic [3:0]   key_wr_idx = '0;
  logic [127:0] key_wr_data = '0;
  logic         err_clr = 1'b0;

  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last, err_key;
  logic [3:0]   in_round = '0;
  logic [31:0]  in_data = '0, out_data;

  logic         in_valid_w = 1'b0, in_ready_w, out_valid_w, out_last_w, err_key_w;
  logic [127:0] in_data_w = '0, out_data_w;

  logic         in_valid_b = 1'b0, in_ready_b, out_valid_b, out_last_b, err_key_b;
  logic [7:0]   in_data_b = '0, out_data_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addroundkey_stream #(.W_LANE(32)) dut (
    .clk(clk), .rst_n(rst_n), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_round(in_round), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err_key(err_key), .err_clr(err_clr)
  );

  addroundkey_stream #(.W_LANE(128)) dut_w (
    .clk(clk), .rst_n(rst_n), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .in_round(4'd0), .in_data(in_data_w), .out_valid(out_valid_w),
    .out_ready(1'b1), .out_data(out_data_w), .out_last(out_last_w),
    .err_key(err_key_w), .err_clr(1'b0)
  );

  addroundkey_stream #(.W_LANE(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_round(4'd0), .in_data(in_data_b), .out_valid(out_valid_b),
    .out_ready(1'b1), .out_data(out_data_b), .out_last(out_last_b),
    .err_key(err_key_b), .err_clr(1'b0)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane32(input logic [127:0] v, input int b);
    return v[127 - 32*b -: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input logic [3:0] idx, input logic [127:0] data);
    key_wr_en   = 1'b1;
    key_wr_idx  = idx;
    key_wr_data = data;
    tick();
    key_wr_en   = 1'b0;
  endtask

  logic [127:0] cat;
  logic [127:0] exp_blk [3];
  logic [3:0]   slot_blk [3];
  int sent, recv, cyc;
  logic in_fire;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err_key", err_key, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();
    write_key(4'd0, K0);

    // Two App. B blocks back to back with out_ready high: no idle cycle.
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_round = 4'd0;
      in_data  = lane32(S, k % 4);
      check("b2b_in_ready", in_ready, 1);
      tick();
      check("b2b_valid", out_valid, 1);
      check("b2b_data", out_data, lane32(E0, k % 4));
      check("b2b_last", out_last, (k % 4) == 3);
    end
    in_valid = 1'b0;
    tick();
    check("b2b_drain", out_valid, 0);

    in_valid_w = 1'b1;
    in_data_w  = S;
    tick();
    in_valid_w = 1'b0;
    check("w128_data", out_data_w, E0);
    check("w128_last", out_last_w, 1);

    cat = '0;
    for (int k = 0; k < 16; k++) begin
      in_valid_b = 1'b1;
      in_data_b  = S[127 - 8*k -: 8];
      tick();
      cat = {cat[119:0], out_data_b};
      check("w8_last", out_last_b, k == 15);
    end
    in_valid_b = 1'b0;
    check("w8_concat", cat, E0);

    // Random backpressure over blocks on slots 0,1,2; in_round scrambled on beats 1..3.
    write_key(4'd1, K1);
    write_key(4'd2, K2);
    exp_blk[0] = E0; exp_blk[1] = E1; exp_blk[2] = E2;
    slot_blk[0] = 4'd0; slot_blk[1] = 4'd1; slot_blk[2] = 4'd2;
    sent = 0; recv = 0; cyc = 0;
    while (recv < 12 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 12);
      in_data   = lane32(S, sent % 4);
      in_round  = (sent % 4 == 0) ? slot_blk[(sent / 4) % 3] : 4'($urandom_range(0, 15));
      #1;
      if (out_valid && out_ready) begin
        check("bp_data", out_data, lane32(exp_blk[recv / 4], recv % 4));
        check("bp_last", out_last, (recv % 4) == 3);
        recv++;
      end
      in_fire = in_valid && in_ready;
      @(posedge clk);
      if (in_fire) sent++;
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_recv_count", recv, 12);
    check("bp_sent_count", sent, 12);
    tick();
    check("bp_drain", out_valid, 0);

    // Stall: output must hold and in_ready must drop.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_round  = 4'd0;
    in_data   = lane32(S, 0);
    tick();
    check("stall_valid", out_valid, 1);
    check("stall_in_ready", in_ready, 0);
    in_data = lane32(S, 1);
    tick();
    check("stall_hold_data", out_data, lane32(E0, 0));
    check("stall_hold_last", out_last, 0);
    out_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      in_data = lane32(S, b);
      tick();
      check("stall_resume", out_data, lane32(E0, b));
    end
    in_valid = 1'b0;
    tick();

    // Out-of-range slot, then never-written slot with a same-cycle clear.
    for (int blk = 0; blk < 2; blk++) begin
      for (int b = 0; b < 4; b++) begin
        in_valid = 1'b1;
        in_round = (b == 0) ? ((blk == 0) ? 4'd15 : 4'd3) : 4'd0;
        in_data  = 32'ha5a5a5a5;
        err_clr  = (blk == 1 && b == 0);
        tick();
        err_clr = 1'b0;
        check("err_passthru", out_data, 32'ha5a5a5a5);
        check("err_sticky", err_key, 1);
      end
      in_valid = 1'b0;
      err_clr  = 1'b1;
      tick();
      err_clr = 1'b0;
      check("err_cleared", err_key, 0);
    end

    // Reset after beat 2, then the block restarts from beat 0.
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      in_round = 4'd0;
      in_data  = lane32(S, b);
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    write_key(4'd0, K0);
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1;
      in_round = 4'd0;
      in_data  = lane32(S, b);
      tick();
      check("post_rst_data", out_data, lane32(E0, b));
      check("post_rst_last", out_last, b == 3);
    end
    in_valid = 1'b0;
    check("post_rst_err", err_key, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
